// File: rtl/mos6502_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mos6502_alu
//  Description : 8-bit ALU for a MOS 6502 core. Performs binary add-with-carry,
//                rotate-right-through-carry, AND, OR and XOR. Result byte,
//                carry and overflow are registered (1-cycle latency).
//  Ports       : clk            - system clock, rising-edge active
//                reset          - asynchronous reset, active-high
//                alu_control    - operation select (ADD/AND/OR/XOR/SR)
//                alu_AI         - operand A (sole operand for SR)
//                alu_BI         - operand B (ignored for SR)
//                alu_carry_in   - carry input (C flag)
//                alu_Y          - registered result byte
//                alu_carry_out  - registered carry result
//                alu_overflow   - registered signed overflow (V)
//  Revision    : 1.0 - initial release
// ============================================================================
module mos6502_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] alu_control,
    input  logic [7:0] alu_AI,
    input  logic [7:0] alu_BI,
    input  logic       alu_carry_in,
    output logic [7:0] alu_Y,
    output logic       alu_carry_out,
    output logic       alu_overflow
);

    // Operation codes shared with the rest of the core.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SR  = 3'd4;

    logic [8:0] w_sum9;
    logic [7:0] y_d;
    logic       carry_d;
    logic       overflow_d;
    logic [7:0] y_q;
    logic       carry_q;
    logic       overflow_q;

    // Binary add only; decimal mode is not supported by this unit.
    assign w_sum9 = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'b0, alu_carry_in};

    always_comb begin
        y_d        = 8'h00;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (alu_control)
            OP_ADD: begin
                y_d        = w_sum9[7:0];
                carry_d    = w_sum9[8];
                // Signed overflow: operands share a sign that the result lacks.
                overflow_d = (alu_AI[7] == alu_BI[7]) && (w_sum9[7] != alu_AI[7]);
            end
            OP_AND: y_d = alu_AI & alu_BI;
            OP_OR:  y_d = alu_AI | alu_BI;
            OP_XOR: y_d = alu_AI ^ alu_BI;
            OP_SR: begin
                // Rotate right through carry: C enters bit 7, bit 0 exits to C.
                y_d     = {alu_carry_in, alu_AI[7:1]};
                carry_d = alu_AI[0];
            end
            default: ; // reserved codes yield all-zero outputs
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q        <= 8'h00;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            y_q        <= y_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign alu_Y         = y_q;
    assign alu_carry_out = carry_q;
    assign alu_overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mos6502_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mos6502_alu
//  Description : Self-checking bench for mos6502_alu: directed vector table,
//                swept operand loops against an arithmetic reference, reset
//                and latency sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mos6502_alu;

    logic       clk;
    logic       reset;
    logic [2:0] alu_control;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry_in;
    logic [7:0] alu_Y;
    logic       alu_carry_out;
    logic       alu_overflow;

    int total;
    int bad;

    mos6502_alu dut (
        .clk           (clk),
        .reset         (reset),
        .alu_control   (alu_control),
        .alu_AI        (alu_AI),
        .alu_BI        (alu_BI),
        .alu_carry_in  (alu_carry_in),
        .alu_Y         (alu_Y),
        .alu_carry_out (alu_carry_out),
        .alu_overflow  (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] y;
        logic       c;
        logic       v;
    } vec_t;

    // Reference model written from the arithmetic definitions.
    function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        int s;
        int ss;
        logic [7:0] y;
        logic c;
        logic v;
        y = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                s  = int'(a) + int'(b) + int'(cin);
                ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
                y  = 8'(s % 256);
                c  = (s > 255);
                v  = (ss > 127) || (ss < -128);
            end
            3'd1: y = a & b;
            3'd2: y = a | b;
            3'd3: y = a ^ b;
            3'd4: begin
                y = 8'(int'(a) / 2 + 128 * int'(cin));
                c = a[0];
            end
            default: ;
        endcase
        return {y, c, v};
    endfunction

    task automatic check(input string name, input logic [7:0] y, input logic c, input logic v);
        total++;
        if (alu_Y !== y || alu_carry_out !== c || alu_overflow !== v) begin
            bad++;
            $display("FAIL %s: got Y=%h C=%b V=%b expected Y=%h C=%b V=%b",
                     name, alu_Y, alu_carry_out, alu_overflow, y, c, v);
        end
    endtask

    // Drive on the falling edge, sample just after the next rising edge.
    task automatic apply(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
        @(negedge clk);
        alu_control  = op;
        alu_AI       = a;
        alu_BI       = b;
        alu_carry_in = cin;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[16];

    initial begin
        logic [9:0] e;
        logic [9:0] prev;
        total = 0;
        bad   = 0;

        vecs[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{3'd0, 8'h50, 8'h50, 1'b1, 8'hA1, 1'b0, 1'b1};
        vecs[4]  = '{3'd0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5]  = '{3'd4, 8'h03, 8'h55, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[6]  = '{3'd4, 8'h02, 8'hAA, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{3'd1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0};
        vecs[8]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0};
        vecs[9]  = '{3'd3, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{3'd5, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{3'd7, 8'h80, 8'h80, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{3'd0, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[14] = '{3'd4, 8'hFF, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0};
        vecs[15] = '{3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset with nonzero inputs: outputs zero before any clock edge.
        alu_control = 3'd0; alu_AI = 8'hFF; alu_BI = 8'hFF; alu_carry_in = 1'b1;
        reset = 1'b1;
        #1;
        check("reset_async", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_hold", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        apply(3'd0, 8'h01, 8'h01, 1'b0);
        check("post_reset_add", 8'h02, 1'b0, 1'b0);

        // Directed vector table.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d", i), vecs[i].y, vecs[i].c, vecs[i].v);
        end

        // ADD sweep: every A, B stepped, both carry values.
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b += 7)
                for (int ci = 0; ci < 2; ci++) begin
                    e = model(3'd0, 8'(a), 8'(b), 1'(ci));
                    apply(3'd0, 8'(a), 8'(b), 1'(ci));
                    check("add_sweep", e[9:2], e[1], e[0]);
                end

        // SR: all A, both carry values.
        for (int a = 0; a < 256; a++)
            for (int ci = 0; ci < 2; ci++) begin
                e = model(3'd4, 8'(a), 8'(a ^ 8'h5A), 1'(ci));
                apply(3'd4, 8'(a), 8'(a ^ 8'h5A), 1'(ci));
                check("sr_sweep", e[9:2], e[1], e[0]);
            end

        // Logic ops sweep.
        for (int op = 1; op < 4; op++)
            for (int a = 0; a < 256; a += 5)
                for (int b = 0; b < 256; b += 3) begin
                    e = model(3'(op), 8'(a), 8'(b), 1'(a & 1));
                    apply(3'(op), 8'(a), 8'(b), 1'(a & 1));
                    check("logic_sweep", e[9:2], e[1], e[0]);
                end

        // Back-to-back: new random operation every cycle; result must hold
        // steady until the next edge and then reflect exactly the new inputs.
        prev = {alu_Y, alu_carry_out, alu_overflow};
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [7:0] a;
            logic [7:0] b;
            logic       ci;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            e  = model(op, a, b, ci);
            @(negedge clk);
            check("b2b_hold", prev[9:2], prev[1], prev[0]);
            alu_control = op; alu_AI = a; alu_BI = b; alu_carry_in = ci;
            @(posedge clk); #1;
            check("b2b_result", e[9:2], e[1], e[0]);
            prev = e;
        end

        // Input changes between edges do not reach the outputs.
        apply(3'd0, 8'h10, 8'h20, 1'b1);
        check("mid_setup", 8'h31, 1'b0, 1'b0);
        alu_AI = 8'hFF; alu_BI = 8'hFF; alu_control = 3'd4;
        #2;
        check("mid_change", 8'h31, 1'b0, 1'b0);

        // Reset mid-operation discards the pending result immediately.
        apply(3'd0, 8'hC0, 8'hC0, 1'b1);
        check("pre_reset", 8'h81, 1'b1, 1'b0);
        @(negedge clk);
        alu_control = 3'd3; alu_AI = 8'hAA; alu_BI = 8'h55;
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_release", 8'hFF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
